// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit. One radix-2 step per clock: shift-add
// for multiplies, restoring division for divides. Every operation takes the
// same number of cycles regardless of opcode or operand values.
//
// Handshake: start is a request that is accepted only while the unit is IDLE
// (busy=0, done=0); requests in any other state are dropped. done is a
// one-cycle pulse and ALUResult holds its value from done until the next
// accepted start. flush aborts any operation and wins over start.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   start        operation request (sampled in IDLE only)
//   flush        synchronous abort, returns to IDLE
//   Operation    funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcA, SrcB   multiplicand/dividend, multiplier/divisor
//   busy         high in PREP, CALC and FIX
//   done         one-cycle pulse, ALUResult valid
//   ALUResult    selected result
//   dbg_state_o  current FSM state (for checkers)
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [OP_WIDTH-1:0]   Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic [2:0]            dbg_state_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic [W-1:0]        a_q, a_d;        // SrcA as issued
    logic [W-1:0]        b_q, b_d;        // SrcB as issued
    logic [W-1:0]        m_q, m_d;        // |multiplicand| or |divisor|
    logic [2*W-1:0]      prod_q, prod_d;  // {hi, lo}: product, or {remainder, quotient}
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;    // product sign / quotient sign
    logic                rneg_q, rneg_d;  // remainder sign (sign of dividend)
    logic [W-1:0]        result_q, result_d;

    // ---------------------------------------------------------------
    // Operand decode (valid from PREP onwards, op_q is latched)
    // ---------------------------------------------------------------
    logic         is_div;
    logic         a_signed, b_signed;
    logic         a_neg, b_neg;
    logic [W-1:0] a_abs, b_abs;

    always_comb begin
        is_div   = op_q[2];
        // Divides: DIV/REM signed (op[0]=0). Multiplies: MULH both, MULHSU A only.
        a_signed = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10);
        b_signed = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01);
        a_neg    = a_signed & a_q[W-1];
        b_neg    = b_signed & b_q[W-1];
        a_abs    = a_neg ? (~a_q + 1'b1) : a_q;
        b_abs    = b_neg ? (~b_q + 1'b1) : b_q;
    end

    // ---------------------------------------------------------------
    // Single radix-2 steps
    // ---------------------------------------------------------------
    logic [W:0]     mul_add;
    logic [2*W-1:0] mul_next;
    logic [W:0]     rem_sh;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;

    always_comb begin
        // Shift-add: add multiplicand to the high half when the multiplier
        // LSB (in the low half) is set, then shift the whole register right.
        mul_add  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
        mul_next = {mul_add, prod_q[W-1:1]};

        // Restoring divide: shift next dividend bit into the partial
        // remainder; a borrow (bit W) means the trial subtraction failed.
        rem_sh   = {prod_q[2*W-1:W], prod_q[W-1]};
        div_diff = rem_sh - {1'b0, m_q};
        if (!div_diff[W]) begin
            div_next = {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[W-1:0], prod_q[W-2:0], 1'b0};
        end
    end

    // ---------------------------------------------------------------
    // Sign correction and result select
    // ---------------------------------------------------------------
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    logic           b_zero;
    logic [W-1:0]   fix_result;

    always_comb begin
        b_zero   = (b_q == '0);
        prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;
        // Divide by zero bypasses the datapath result entirely.
        quo_fix  = b_zero ? {W{1'b1}}
                          : (neg_q ? (~prod_q[W-1:0] + 1'b1) : prod_q[W-1:0]);
        rem_fix  = b_zero ? a_q
                          : (rneg_q ? (~prod_q[2*W-1:W] + 1'b1) : prod_q[2*W-1:W]);
        if (!is_div) begin
            fix_result = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        end else begin
            fix_result = op_q[1] ? rem_fix : quo_fix;
        end
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = S_CALC;
            S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        busy        = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
        done        = (state_q == S_DONE);
        dbg_state_o = state_q;
        ALUResult   = result_q;
    end

    // ---------------------------------------------------------------
    // Datapath next-state
    // ---------------------------------------------------------------
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d = Operation;
                    a_d  = SrcA;
                    b_d  = SrcB;
                end
            end
            S_PREP: begin
                if (is_div) begin
                    prod_d = {{W{1'b0}}, a_abs};
                    m_d    = b_abs;
                end else begin
                    prod_d = {{W{1'b0}}, b_abs};
                    m_d    = a_abs;
                end
                neg_d  = a_neg ^ b_neg;
                rneg_d = a_neg;
                cnt_d  = CW'(W);
            end
            S_CALC: begin
                prod_d = is_div ? div_next : mul_next;
                cnt_d  = cnt_q - 1'b1;
            end
            S_FIX: begin
                if (!flush) result_d = fix_result;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed test of muldiv_unit (DATA_WIDTH=32): reset values, every opcode
// with hand-computed results, divide-by-zero and signed overflow, fixed
// latency and busy width, start ignored while busy and in DONE, flush, and
// asynchronous reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   Operation = '0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] ALUResult;
    logic [2:0]   dbg_state;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .flush       (flush),
        .Operation   (Operation),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .busy        (busy),
        .done        (done),
        .ALUResult   (ALUResult),
        .dbg_state_o (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int tests  = 0;
    int failed = 0;
    int n;         // rising edges since (and including) the edge sampling start
    int busy_cnt;  // samples with busy high after those edges

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        if (busy) busy_cnt++;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || done) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle before start", {31'b0, busy}, 32'd0);
    endtask

    task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        start     = 1'b1;
        n         = 0;
        busy_cnt  = 0;
        tick();
        start     = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [W-1:0] exp);
        while (!done && n < 200) tick();
        check(tag, ALUResult, exp);
        check({tag, " latency"}, W'(n), 32'd35);
        check({tag, " busy cycles"}, W'(busy_cnt), 32'd34);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp);
        launch(op, a, b);
        collect(tag, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic any_done;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", ALUResult, 32'd0);
        rst_n = 1'b1;

        // First edge after reset release accepts start
        launch(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        check("accept after reset", {31'b0, busy}, 32'd1);
        collect("MUL 7*-3", 32'hFFFF_FFEB);

        // Multiplies
        run_op("MULH min*min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("MULHU ff*ff",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("MULHSU ff*ff",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("MULH -3*5",     OP_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF);
        run_op("MULHSU 2^30*8", OP_MULHSU, 32'h4000_0000, 32'd8,         32'h0000_0002);
        run_op("MUL lo",        OP_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780);

        // Divides
        run_op("DIV -7/2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_op("REM -7/2",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_op("DIVU 100/7",    OP_DIVU,   32'd100,       32'd7,         32'd14);
        run_op("REMU 100/7",    OP_REMU,   32'd100,       32'd7,         32'd2);
        run_op("DIV 20/-3",     OP_DIV,    32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA);
        run_op("REM 20/-3",     OP_REM,    32'd20,        32'hFFFF_FFFD, 32'd2);

        // Divide by zero and signed overflow
        run_op("DIVU 5/0",      OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF);
        run_op("REM 5/0",       OP_REM,    32'd5,         32'd0,         32'd5);
        run_op("DIV -5/0",      OP_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF);
        run_op("REMU max/0",    OP_REMU,   32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF);
        run_op("DIV ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("REM ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // start held through DONE is ignored there, accepted in the next IDLE
        run_op("DIVU 100/7 b", OP_DIVU, 32'd100, 32'd7, 32'd14);
        Operation = OP_MUL;
        SrcA      = 32'd3;
        SrcB      = 32'd3;
        start     = 1'b1;
        tick();
        check("start ignored in DONE", {31'b0, busy}, 32'd0);
        check("result held after done", ALUResult, 32'd14);
        n        = 0;
        busy_cnt = 0;
        tick();
        start = 1'b0;
        check("start accepted in IDLE", {31'b0, busy}, 32'd1);
        collect("MUL 3*3 back-to-back", 32'd9);

        // start while busy changes nothing
        launch(OP_MUL, 32'd6, 32'd7);
        repeat (5) tick();
        Operation = OP_DIVU;
        SrcA      = 32'd1000;
        SrcB      = 32'd3;
        start     = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        collect("MUL 6*7 start ignored", 32'd42);

        // flush in CALC (step 10)
        launch(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        while (n < 11) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush done", {31'b0, done}, 32'd0);
        check("flush result kept", ALUResult, 32'd42);
        any_done = 1'b0;
        repeat (40) begin
            tick();
            if (done) any_done = 1'b1;
        end
        check("no done after flush", {31'b0, any_done}, 32'd0);
        check("result kept after flush", ALUResult, 32'd42);

        // flush wins over start in IDLE
        Operation = OP_MUL;
        SrcA      = 32'd2;
        SrcB      = 32'd2;
        start     = 1'b1;
        flush     = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush over start", {31'b0, busy}, 32'd0);
        run_op("REMU after flush", OP_REMU, 32'd100, 32'd7, 32'd2);

        // asynchronous reset mid-CALC
        launch(OP_MUL, 32'h1234_5678, 32'h10);
        while (n < 12) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset busy", {31'b0, busy}, 32'd0);
        check("async reset done", {31'b0, done}, 32'd0);
        check("async reset result", ALUResult, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("accept after mid reset", {31'b0, busy}, 32'd1);
        collect("DIV after reset", 32'hFFFF_FFFD);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
